// File: rtl/token_glb_arbiter.sv
// rtl/token_glb_arbiter.sv - GLB SRAM port arbiter for the token-engine FIFO controllers
module token_glb_arbiter #(
    parameter int NUM_RD    = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arb_clear_i,
    input  logic [NUM_RD-1:0]        rd_req_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_permit_o,
    output logic [NUM_RD-1:0]        rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    input  logic                     wr_req_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     wr_permit_o,
    output logic                     glb_en_o,
    output logic                     glb_we_o,
    output logic [ADDR_W-1:0]        glb_addr_o,
    output logic [DATA_W-1:0]        glb_wdata_o,
    input  logic [DATA_W-1:0]        glb_rdata_i,
    output logic                     fifo_glb_busy_o
);

    localparam int OW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       burst_cnt_q, burst_cnt_d;
    logic                wr_hold_q, wr_hold_d;
    logic [NUM_RD-1:0]   rd_valid_q, rd_valid_d;

    logic                owner_req;
    logic [ADDR_W-1:0]   owner_addr;
    logic [OW-1:0]       rr_pick;
    logic [OW-1:0]       hi_pick;
    logic [OW-1:0]       lo_pick;
    logic                hi_found;
    logic                last_beat;

    // Select the current read owner's live request and address.
    always_comb begin
        owner_req  = 1'b0;
        owner_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (owner_q == OW'(i)) begin
                owner_req  = rd_req_i[i];
                owner_addr = rd_addr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Round-robin pick: lowest requester at or after rr_ptr, else lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (rd_req_i[i]) begin
                if (OW'(i) >= rr_ptr_q) begin
                    hi_pick  = OW'(i);
                    hi_found = 1'b1;
                end
                lo_pick = OW'(i);
            end
        end
        rr_pick = hi_found ? hi_pick : lo_pick;
    end

    // Permits and GLB port drive follow the registered owner and the live request.
    always_comb begin
        rd_permit_o = '0;
        wr_permit_o = 1'b0;
        glb_en_o    = 1'b0;
        glb_we_o    = 1'b0;
        glb_addr_o  = '0;
        glb_wdata_o = '0;
        case (state_q)
            ST_RD: begin
                for (int i = 0; i < NUM_RD; i++) begin
                    if (owner_q == OW'(i)) begin
                        rd_permit_o[i] = rd_req_i[i];
                    end
                end
                glb_en_o   = owner_req;
                glb_addr_o = owner_addr;
            end
            ST_WR: begin
                wr_permit_o = wr_req_i;
                glb_en_o    = wr_req_i;
                glb_we_o    = wr_req_i;
                glb_addr_o  = wr_addr_i;
                glb_wdata_o = wr_data_i;
            end
            default: begin
            end
        endcase
    end

    // Next-state: arbitration in IDLE, burst accounting and exit bookkeeping, soft clear on top.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wr_hold_d   = wr_hold_q;
        rd_valid_d  = rd_permit_o;
        last_beat   = (burst_cnt_q == CW'(BURST_MAX - 1));
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (wr_req_i && !(wr_hold_q && (|rd_req_i))) begin
                    state_d = ST_WR;
                end else if (|rd_req_i) begin
                    state_d = ST_RD;
                    owner_d = rr_pick;
                end
            end
            ST_RD: begin
                if (!owner_req || last_beat) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (owner_q == OW'(NUM_RD - 1)) ? '0 : owner_q + 1'b1;
                    wr_hold_d   = 1'b0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            ST_WR: begin
                if (!wr_req_i || last_beat) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                    wr_hold_d   = |rd_req_i;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
        if (arb_clear_i) begin
            state_d     = ST_IDLE;
            rr_ptr_d    = '0;
            wr_hold_d   = 1'b0;
            burst_cnt_d = '0;
            rd_valid_d  = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_hold_q   <= 1'b0;
            rd_valid_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_hold_q   <= wr_hold_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_valid_o      = rd_valid_q;
    assign rd_data_o       = glb_rdata_i;
    assign fifo_glb_busy_o = (state_q != ST_IDLE);

endmodule
